// File: rtl/con_u_cmp.sv
// Branch-condition unit: evaluates an IR condition code against the bus value
// and, for two-operand codes, against operand register A. The result is latched into con_out.
module con_u_cmp #(
    parameter int w     = 32,
    parameter int CW    = 4,
    parameter int C_LSB = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [w-1:0] bus,
    input  logic [w-1:0] IR,
    input  logic         a_in,
    input  logic         con_in,
    input  logic         con_clr,
    output logic         con_out,
    output logic         con_valid,
    output logic [w-1:0] a_q
);

    typedef enum logic [3:0] {
        C_NEVER  = 4'd0,
        C_ALWAYS = 4'd1,
        C_ZERO   = 4'd2,
        C_NZERO  = 4'd3,
        C_GE0    = 4'd4,
        C_LT0    = 4'd5,
        C_GT0    = 4'd6,
        C_LE0    = 4'd7,
        C_EQ     = 4'd8,
        C_NE     = 4'd9,
        C_LT_S   = 4'd10,
        C_GE_S   = 4'd11,
        C_LT_U   = 4'd12,
        C_GE_U   = 4'd13
    } cond_e;

    logic [CW-1:0] code;
    logic          b_zero;
    logic          b_neg;
    logic          a_eq;
    logic          a_lt_s;
    logic          a_lt_u;
    logic          result;

    assign code   = IR[C_LSB +: CW];
    assign b_zero = (bus == '0);
    assign b_neg  = bus[w-1];
    assign a_eq   = (a_q == bus);
    assign a_lt_u = (a_q < bus);
    // Relational signed compare: no subtraction, so there is no overflow to correct.
    assign a_lt_s = ($signed(a_q) < $signed(bus));

    always_comb begin
        result = 1'b0;
        case (code)
            C_NEVER:  result = 1'b0;
            C_ALWAYS: result = 1'b1;
            C_ZERO:   result = b_zero;
            C_NZERO:  result = !b_zero;
            C_GE0:    result = !b_neg;
            C_LT0:    result = b_neg;
            C_GT0:    result = !b_zero && !b_neg;
            C_LE0:    result = b_zero || b_neg;
            C_EQ:     result = a_eq;
            C_NE:     result = !a_eq;
            C_LT_S:   result = a_lt_s;
            C_GE_S:   result = !a_lt_s;
            C_LT_U:   result = a_lt_u;
            C_GE_U:   result = !a_lt_u;
            default:  result = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            con_out   <= 1'b0;
            con_valid <= 1'b0;
            a_q       <= '0;
        end else begin
            if (con_in) begin
                con_out   <= result;
                con_valid <= 1'b1;
            end else if (con_clr) begin
                con_out   <= 1'b0;
                con_valid <= 1'b0;
            end
            if (a_in) begin
                a_q <= bus;
            end
        end
    end

endmodule

// File: tb/tb_con_u_cmp.sv
// Bench for con_u_cmp: directed scenarios with literal expectations plus random
// traffic checked every cycle against a behavioural model (w=32 and w=16 instances).
module tb_con_u_cmp;

    logic        clk = 1'b0;
    logic        rst, a_in, con_in, con_clr;
    logic [31:0] bus, ir;
    logic [15:0] bus2, ir2;
    logic        con_out, con_valid, con_out2, con_valid2;
    logic [31:0] a_q;
    logic [15:0] a_q2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    con_u_cmp #(.w(32), .CW(4), .C_LSB(0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .IR(ir), .a_in(a_in), .con_in(con_in),
        .con_clr(con_clr), .con_out(con_out), .con_valid(con_valid), .a_q(a_q)
    );

    con_u_cmp #(.w(16), .CW(4), .C_LSB(8)) dut16 (
        .clk(clk), .rst(rst), .bus(bus2), .IR(ir2), .a_in(a_in), .con_in(con_in),
        .con_clr(con_clr), .con_out(con_out2), .con_valid(con_valid2), .a_q(a_q2)
    );

    // Condition rules evaluated on plain integers
    function automatic bit eval(int code, longint unsigned a, longint unsigned b, int width);
        longint half = longint'(1) << (width - 1);
        longint sa   = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
        longint sb   = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
        case (code)
            0:  return 1'b0;
            1:  return 1'b1;
            2:  return b == 0;
            3:  return b != 0;
            4:  return sb >= 0;
            5:  return sb < 0;
            6:  return sb > 0;
            7:  return sb <= 0;
            8:  return a == b;
            9:  return a != b;
            10: return sa < sb;
            11: return sa >= sb;
            12: return a < b;
            13: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    longint unsigned m_a = 0, m2_a = 0;
    bit m_con = 0, m_val = 0, m2_con = 0, m2_val = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_a <= 0; m_con <= 0; m_val <= 0;
            m2_a <= 0; m2_con <= 0; m2_val <= 0;
        end else begin
            if (con_in) begin
                m_con  <= eval(int'(ir[3:0]), m_a, longint'(bus), 32);
                m2_con <= eval(int'(ir2[11:8]), m2_a, longint'(bus2), 16);
                m_val  <= 1'b1;
                m2_val <= 1'b1;
            end else if (con_clr) begin
                m_con <= 0; m_val <= 0; m2_con <= 0; m2_val <= 0;
            end
            if (a_in) begin
                m_a  <= longint'(bus);
                m2_a <= longint'(bus2);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model con_out", {31'd0, con_out}, {31'd0, m_con});
            chk("model con_valid", {31'd0, con_valid}, {31'd0, m_val});
            chk("model a_q", a_q, m_a[31:0]);
            chk("model con_out16", {31'd0, con_out2}, {31'd0, m2_con});
            chk("model con_valid16", {31'd0, con_valid2}, {31'd0, m2_val});
            chk("model a_q16", {16'd0, a_q2}, {16'd0, m2_a[15:0]});
        end
    end

    // Drive one cycle (inputs change just after negedge), return at the next negedge
    task automatic cyc(input bit r, input bit ai, input bit ci, input bit cc,
                       input logic [31:0] b, input logic [3:0] code,
                       input logic [15:0] b2 = 16'h0, input logic [3:0] code2 = 4'd0);
        rst = r; a_in = ai; con_in = ci; con_clr = cc;
        bus = b;
        ir = ($urandom & 32'hFFFF_FFF0) | {28'd0, code};
        bus2 = b2;
        ir2 = (16'($urandom) & 16'hF0FF) | {4'd0, code2, 8'd0};
        @(negedge clk);
    endtask

    int exp1 [3][6] = '{'{1, 0, 1, 0, 0, 1}, '{0, 1, 1, 0, 1, 0}, '{0, 1, 0, 1, 0, 1}};
    logic [31:0] bvals [3] = '{32'h0, 32'h1, 32'hFFFF_FFFF};

    initial begin
        rst = 1'b1; a_in = 0; con_in = 0; con_clr = 0; bus = '0; ir = '0; bus2 = '0; ir2 = '0;
        cyc(1, 0, 0, 0, 32'h0, 4'd0);
        chk_en = 1'b1;
        chk("reset con_out", {31'd0, con_out}, 32'd0);
        chk("reset con_valid", {31'd0, con_valid}, 32'd0);
        chk("reset a_q", a_q, 32'd0);

        // Sign and zero tests
        for (int i = 0; i < 3; i++) begin
            for (int c = 2; c <= 7; c++) begin
                cyc(0, 0, 1, 0, bvals[i], 4'(c));
                chk($sformatf("code%0d B=%0h", c, bvals[i]), {31'd0, con_out}, 32'(exp1[i][c-2]));
            end
        end
        chk("valid after eval", {31'd0, con_valid}, 32'd1);

        // Signed/unsigned extremes, both widths
        cyc(0, 1, 0, 0, 32'h8000_0000, 4'd0, 16'h8000, 4'd0);
        cyc(0, 0, 1, 0, 32'h7FFF_FFFF, 4'd10, 16'h7FFF, 4'd10);
        chk("lt_s extreme", {31'd0, con_out}, 32'd1);
        chk("lt_s extreme w16", {31'd0, con_out2}, 32'd1);
        cyc(0, 0, 1, 0, 32'h7FFF_FFFF, 4'd11, 16'h7FFF, 4'd13);
        chk("ge_s extreme", {31'd0, con_out}, 32'd0);
        chk("ge_u extreme w16", {31'd0, con_out2}, 32'd1);
        cyc(0, 0, 1, 0, 32'h7FFF_FFFF, 4'd12);
        chk("lt_u extreme", {31'd0, con_out}, 32'd0);
        cyc(0, 0, 1, 0, 32'h7FFF_FFFF, 4'd13);
        chk("ge_u extreme", {31'd0, con_out}, 32'd1);
        cyc(0, 1, 0, 0, 32'd5, 4'd0);
        cyc(0, 0, 1, 0, 32'd5, 4'd8);
        chk("eq 5", {31'd0, con_out}, 32'd1);
        cyc(0, 0, 1, 0, 32'd5, 4'd9);
        chk("ne 5", {31'd0, con_out}, 32'd0);

        // Load and compare in the same cycle use the old A
        cyc(0, 1, 0, 0, 32'd7, 4'd0);
        cyc(0, 1, 1, 0, 32'd7, 4'd8);
        chk("same-cycle eq old A", {31'd0, con_out}, 32'd1);
        chk("same-cycle a_q", a_q, 32'd7);
        cyc(0, 1, 1, 0, 32'd9, 4'd8);
        chk("same-cycle ne old A", {31'd0, con_out}, 32'd0);
        chk("same-cycle a_q 9", a_q, 32'd9);

        // Hold, clear, set-over-clear
        cyc(0, 0, 1, 0, $urandom, 4'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, $urandom, 4'($urandom));
            chk("hold con_out", {31'd0, con_out}, 32'd1);
        end
        cyc(0, 0, 0, 1, $urandom, 4'd1);
        chk("clr con_out", {31'd0, con_out}, 32'd0);
        chk("clr con_valid", {31'd0, con_valid}, 32'd0);
        cyc(0, 0, 1, 1, $urandom, 4'd1);
        chk("in over clr con_out", {31'd0, con_out}, 32'd1);
        chk("in over clr con_valid", {31'd0, con_valid}, 32'd1);

        // Never / reserved
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, $urandom, (i == 0) ? 4'd0 : 4'(13 + i));
            chk("never/reserved", {31'd0, con_out}, 32'd0);
            chk("reserved valid", {31'd0, con_valid}, 32'd1);
        end
        cyc(0, 0, 1, 0, $urandom, 4'd1);
        chk("always", {31'd0, con_out}, 32'd1);

        // Reset mid-sequence
        cyc(0, 1, 1, 0, 32'h1234, 4'd1);
        cyc(1, 0, 1, 0, 32'h1234, 4'd1);
        chk("mid rst con_out", {31'd0, con_out}, 32'd0);
        chk("mid rst con_valid", {31'd0, con_valid}, 32'd0);
        chk("mid rst a_q", a_q, 32'd0);
        cyc(0, 0, 1, 0, 32'd0, 4'd8);
        chk("eq A=0 after rst", {31'd0, con_out}, 32'd1);

        // Random traffic, biased toward boundary bus values
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] b;
            logic [15:0] b2;
            case ($urandom_range(0, 5))
                0: begin b = 32'h0; b2 = 16'h0; end
                1: begin b = 32'h8000_0000; b2 = 16'h8000; end
                2: begin b = 32'h7FFF_FFFF; b2 = 16'h7FFF; end
                3: begin b = 32'hFFFF_FFFF; b2 = 16'hFFFF; end
                4: begin b = m_a[31:0]; b2 = m2_a[15:0]; end
                default: begin b = $urandom; b2 = 16'($urandom); end
            endcase
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                b, 4'($urandom), b2, 4'($urandom));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
